fetch_sequencer: RTL

//  Sequences the nibble-serial Fetcher for the CPU core: issues fetch_start, waits for fetch_done, and returns fetch_done_ack.

---
 rtl/opcode_pkg.sv | 26 ++
 rtl/fetch_sequencer.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/opcode_pkg.sv
// Shared opcode helpers and the fetch sequencer state type.
package opcode_pkg;

  typedef enum logic [3:0] {
    FS_IDLE,
    FS_F1_REQ,
    FS_F1_WAIT,
    FS_F1_ACK,
    FS_F2_REQ,
    FS_F2_WAIT,
    FS_F2_ACK,
    FS_ISSUE,
    FS_FAULT
  } fetch_seq_state_e;

  localparam logic [2:0] FETCH_INST_LEN = 3'd1;

  // Two-word opcodes: JCN, JUN, JMS, ISZ, and FIM (OPR 2 with OPA[0] clear).
  function automatic logic is_two_word(input logic [7:0] w);
    logic [3:0] opr;
    opr = w[7:4];
    return (opr == 4'h1) || (opr == 4'h4) || (opr == 4'h5) || (opr == 4'h7) ||
           ((w & 8'hF1) == 8'h20);
  endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Drives the nibble-serial Fetcher, predecodes word1 for a second fetch and
// hands complete instructions to execute over valid/ready; owns the PC.
module fetch_sequencer
  import opcode_pkg::*;
#(
  parameter logic [11:0] RESET_PC      = 12'h000,
  parameter int unsigned FETCH_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  output logic [11:0] fetch_pc,
  output logic        fetch_start,
  output logic [2:0]  inst_len,
  input  logic        fetch_done,
  input  logic [15:0] fetch_inst,
  output logic        fetch_done_ack,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [15:0] inst_word,
  output logic        inst_two_word,
  output logic [11:0] inst_pc,
  input  logic        pc_load,
  input  logic [11:0] pc_load_value,
  output logic        fetch_fault
);

  localparam int unsigned   TW      = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(FETCH_TIMEOUT - 1);

  fetch_seq_state_e state_q;
  logic [11:0]      pc_q;
  logic [11:0]      fetch_pc_q;
  logic [11:0]      inst_pc_q;
  logic [11:0]      pc_next_d;
  logic [7:0]       word1_q;
  logic [7:0]       word2_q;
  logic [15:0]      inst_word_q;
  logic [TW-1:0]    cnt_q;
  logic             fetch_start_q;
  logic             fetch_done_ack_q;
  logic             inst_valid_q;
  logic             inst_two_word_q;
  logic             fetch_fault_q;
  logic             unused_inst_low;

  assign unused_inst_low = ^fetch_inst[7:0];

  always_comb begin
    pc_next_d = pc_load ? pc_load_value
                        : inst_pc_q + (inst_two_word_q ? 12'd4 : 12'd2);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= FS_IDLE;
      pc_q             <= RESET_PC;
      fetch_pc_q       <= RESET_PC;
      inst_pc_q        <= '0;
      word1_q          <= '0;
      word2_q          <= '0;
      inst_word_q      <= '0;
      cnt_q            <= '0;
      fetch_start_q    <= 1'b0;
      fetch_done_ack_q <= 1'b0;
      inst_valid_q     <= 1'b0;
      inst_two_word_q  <= 1'b0;
      fetch_fault_q    <= 1'b0;
    end else begin
      fetch_start_q    <= 1'b0;
      fetch_done_ack_q <= 1'b0;
      case (state_q)
        FS_IDLE: begin
          if (run && !fetch_fault_q) begin
            fetch_pc_q <= pc_q;
            state_q    <= FS_F1_REQ;
          end
        end
        FS_F1_REQ, FS_F2_REQ: begin
          // Hold off the start pulse while the Fetcher still shows done.
          if (!fetch_done) begin
            fetch_start_q <= 1'b1;
            cnt_q         <= '0;
            state_q       <= (state_q == FS_F1_REQ) ? FS_F1_WAIT : FS_F2_WAIT;
          end
        end
        FS_F1_WAIT, FS_F2_WAIT: begin
          if (fetch_done) begin
            if (state_q == FS_F1_WAIT) begin
              word1_q <= fetch_inst[15:8];
              word2_q <= '0;
              state_q <= FS_F1_ACK;
            end else begin
              word2_q <= fetch_inst[15:8];
              state_q <= FS_F2_ACK;
            end
            fetch_done_ack_q <= 1'b1;
          end else if (cnt_q == TO_LAST) begin
            fetch_fault_q <= 1'b1;
            state_q       <= FS_FAULT;
          end else begin
            cnt_q <= cnt_q + TW'(1);
          end
        end
        FS_F1_ACK: begin
          if (is_two_word(word1_q)) begin
            fetch_pc_q <= pc_q + 12'd2;
            state_q    <= FS_F2_REQ;
          end else begin
            inst_valid_q    <= 1'b1;
            inst_word_q     <= {word1_q, word2_q};
            inst_two_word_q <= 1'b0;
            inst_pc_q       <= pc_q;
            state_q         <= FS_ISSUE;
          end
        end
        FS_F2_ACK: begin
          inst_valid_q    <= 1'b1;
          inst_word_q     <= {word1_q, word2_q};
          inst_two_word_q <= 1'b1;
          inst_pc_q       <= pc_q;
          state_q         <= FS_ISSUE;
        end
        FS_ISSUE: begin
          if (inst_ready) begin
            pc_q         <= pc_next_d;
            fetch_pc_q   <= pc_next_d;
            inst_valid_q <= 1'b0;
            state_q      <= run ? FS_F1_REQ : FS_IDLE;
          end
        end
        default: begin
          fetch_fault_q <= 1'b1;
          state_q       <= FS_FAULT;
        end
      endcase
    end
  end

  assign fetch_pc       = fetch_pc_q;
  assign fetch_start    = fetch_start_q;
  assign inst_len       = FETCH_INST_LEN;
  assign fetch_done_ack = fetch_done_ack_q;
  assign inst_valid     = inst_valid_q;
  assign inst_word      = inst_word_q;
  assign inst_two_word  = inst_two_word_q;
  assign inst_pc        = inst_pc_q;
  assign fetch_fault    = fetch_fault_q;

endmodule
